// File: rtl/nibble_serial_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer:
// FSM state encoding, slice width and the index-width helper.
package nibble_serial_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Width of a counter addressing 'nibbles' positions; never below 1 bit.
  function automatic int idx_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/adder_4bit.sv
// Single 4-bit add/subtract slice: s = a + (b ^ {4{sm}}) + c_in.
// The caller seeds c_in with sm on the first nibble to form two's complement.
module adder_4bit
  import nibble_serial_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                c_in,
  input  logic                sm,
  output logic [NIBBLE_W-1:0] s,
  output logic                c_out
);

  logic [NIBBLE_W-1:0] w_b_eff;

  assign w_b_eff      = b ^ {NIBBLE_W{sm}};
  assign {c_out, s}   = {1'b0, a} + {1'b0, w_b_eff} + {{NIBBLE_W{1'b0}}, c_in};

endmodule

// File: rtl/nibble_serial_addsub.sv
// Multi-word add/subtract sequencer time-sharing one 4-bit slice, LSB nibble first.
// Optional signed-overflow flag is built only when NIBBLE_SERIAL_OVF_EN is defined.
module nibble_serial_addsub
  import nibble_serial_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        sub,
  input  logic [NIBBLE_W*NIBBLES-1:0] op_a,
  input  logic [NIBBLE_W*NIBBLES-1:0] op_b,
  output logic                        busy,
  output logic                        done,
  output logic [NIBBLE_W*NIBBLES-1:0] result,
  output logic                        carry_out,
  output logic                        overflow
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = idx_width(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e r_state, w_next_state;

  logic [W-1:0]        r_a, r_b, r_acc, r_result;
  logic                r_sub, r_carry, r_carry_out;
  logic [IDX_W-1:0]    r_idx;

  logic [NIBBLE_W-1:0] w_a_nib, w_b_nib, w_sum;
  logic                w_c;
  logic                w_last;
  logic                w_accept;
  logic [W-1:0]        w_acc_next;

  assign w_accept = (r_state == ST_IDLE) && start;
  assign w_last   = (r_idx == LAST_IDX);
  assign w_a_nib  = r_a[r_idx*NIBBLE_W +: NIBBLE_W];
  assign w_b_nib  = r_b[r_idx*NIBBLE_W +: NIBBLE_W];

  adder_4bit u_slice (
    .a     (w_a_nib),
    .b     (w_b_nib),
    .c_in  (r_carry),
    .sm    (r_sub),
    .s     (w_sum),
    .c_out (w_c)
  );

  // Partial result with the current nibble merged into its slot.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_acc_next = r_acc;
    w_acc_next[r_idx*NIBBLE_W +: NIBBLE_W] = w_sum;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: if (start)  w_next_state = ST_RUN;
      ST_RUN:  if (w_last) w_next_state = ST_DONE;
      ST_DONE:             w_next_state = ST_IDLE;
      default:             w_next_state = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (r_state == ST_RUN);
    done = (r_state == ST_DONE);
  end

  // Datapath: capture on acceptance, one nibble per RUN cycle, publish on the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_sub       <= 1'b0;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      r_acc       <= '0;
      r_result    <= '0;
      r_carry_out <= 1'b0;
    end else if (w_accept) begin
      r_a         <= op_a;
      r_b         <= op_b;
      r_sub       <= sub;
      r_carry     <= sub;
      r_idx       <= '0;
      r_acc       <= '0;
      r_result    <= '0;
      r_carry_out <= 1'b0;
    end else if (r_state == ST_RUN) begin
      r_acc   <= w_acc_next;
      r_carry <= w_c;
      if (w_last) begin
        r_idx       <= '0;
        r_result    <= w_acc_next;
        r_carry_out <= w_c;
      end else begin
        r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

  assign result    = r_result;
  assign carry_out = r_carry_out;

`ifdef NIBBLE_SERIAL_OVF_EN
  logic r_overflow;

  // Same-sign operands (after B inversion) producing an opposite-sign sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_accept) begin
      r_overflow <= 1'b0;
    end else if ((r_state == ST_RUN) && w_last) begin
      r_overflow <= (r_a[W-1] ~^ (r_b[W-1] ^ r_sub)) & (w_sum[NIBBLE_W-1] ^ r_a[W-1]);
    end
  end

  assign overflow = r_overflow;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Self-checking bench for nibble_serial_addsub (NIBBLES=4): directed table,
// corner sequences (ignored start, mid-RUN reset) and random ops vs. an arithmetic model.
module tb_nibble_serial_addsub;

  localparam int NIB     = 4;
  localparam int W       = 4 * NIB;
  localparam int MAX_LAT = 50;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] op_a, op_b;
  logic         busy, done;
  logic [W-1:0] result;
  logic         carry_out, overflow;

  int n_checks;
  int n_errors;

  nibble_serial_addsub #(.NIBBLES(NIB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sub       (sub),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_res;
    logic         exp_co;
    logic         exp_ov;   // value when the overflow feature is built
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic ovf_en();
`ifdef NIBBLE_SERIAL_OVF_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Reference: plain integer arithmetic. Returns {overflow, carry, result}.
  function automatic logic [W+1:0] model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, sr;
    logic [W-1:0] r;
    logic c, ov;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!s) begin
      {c, r} = {1'b0, a} + {1'b0, b};
      sr = sa + sb;
    end else begin
      r  = a - b;
      c  = (a >= b);
      sr = sa - sb;
    end
    ov = (sr > 32767) || (sr < -32768);
    return {ov & ovf_en(), c, r};
  endfunction

  // Issue one operation and wait (bounded) for done; sampling on negedges.
  task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] res, output logic co, output logic ov,
                        output int lat, output logic busy_bad);
    busy_bad = 1'b0;
    @(negedge clk);
    start = 1'b1; sub = s; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0; sub = ~s; op_a = W'($urandom); op_b = W'($urandom);
    lat = 1;
    while (!done && lat < MAX_LAT) begin
      if (!busy) busy_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (busy) busy_bad = 1'b1;
    res = result; co = carry_out; ov = overflow;
  endtask

  vec_t         vecs[8];
  logic [W-1:0] res;
  logic         co, ov, bb;
  int           lat;
  logic [W+1:0] m;
  int           pulses;
  logic [W-1:0] res_at_done;

  initial begin
    n_checks = 0;
    n_errors = 0;
    start = 1'b0; sub = 1'b0; op_a = '0; op_b = '0;

    vecs[0] = '{1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 16'h0007, 16'h0005, 16'h0002, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy",     busy,      1'b0);
    check("reset done",     done,      1'b0);
    check("reset result",   result,    '0);
    check("reset carry",    carry_out, 1'b0);
    check("reset overflow", overflow,  1'b0);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].sub, vecs[i].a, vecs[i].b, res, co, ov, lat, bb);
      check($sformatf("vec%0d latency", i),  lat, NIB + 1);
      check($sformatf("vec%0d busy", i),     bb, 1'b0);
      check($sformatf("vec%0d result", i),   res, vecs[i].exp_res);
      check($sformatf("vec%0d carry", i),    co, vecs[i].exp_co);
      check($sformatf("vec%0d overflow", i), ov, vecs[i].exp_ov & ovf_en());
      @(negedge clk);
      check($sformatf("vec%0d done pulse", i), done, 1'b0);
      check($sformatf("vec%0d held", i),       result, vecs[i].exp_res);
    end

    // start during RUN is ignored: one done, first operands' result
    @(negedge clk);
    start = 1'b1; sub = 1'b0; op_a = 16'h1234; op_b = 16'h1111;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; sub = 1'b1; op_a = 16'hAAAA; op_b = 16'h0F0F;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    res_at_done = '0;
    for (int c = 0; c < 14; c++) begin
      if (done) begin
        pulses++;
        res_at_done = result;
      end
      @(negedge clk);
    end
    check("ignore start pulses", pulses, 1);
    check("ignore start result", res_at_done, 16'h2345);
    check("ignore start idle",   busy, 1'b0);

    // Reset after two nibbles of RUN
    @(negedge clk);
    start = 1'b1; sub = 1'b0; op_a = 16'h0FFF; op_b = 16'h0FFF;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("pre-reset busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid reset busy",     busy,      1'b0);
    check("mid reset done",     done,      1'b0);
    check("mid reset result",   result,    '0);
    check("mid reset carry",    carry_out, 1'b0);
    check("mid reset overflow", overflow,  1'b0);
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done) pulses++;
      if (c == 2) rst_n = 1'b1;
    end
    check("mid reset no done", pulses, 0);
    run_op(1'b0, 16'h0FFF, 16'h0FFF, res, co, ov, lat, bb);
    check("post reset latency", lat, NIB + 1);
    check("post reset result",  res, 16'h1FFE);
    check("post reset carry",   co, 1'b0);

    // Randomized ops against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      logic         rs;
      logic [W-1:0] ra, rb;
      rs = 1'($urandom_range(0, 1));
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 8 == 0) ra = 16'h7FFF + W'(i);
      m = model(rs, ra, rb);
      run_op(rs, ra, rb, res, co, ov, lat, bb);
      check($sformatf("rnd%0d latency", i), lat, NIB + 1);
      check($sformatf("rnd%0d busy", i),    bb, 1'b0);
      check($sformatf("rnd%0d result", i),  res, m[W-1:0]);
      check($sformatf("rnd%0d carry", i),   co, m[W]);
      check($sformatf("rnd%0d overflow", i), ov, m[W+1]);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
